// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - CDB request/broadcast bundle between functional units and the arbiter (optional CDB_ARBITER_STATS_EN counters)
interface cdb_arbiter_if #(
  parameter int NUM_SRC = 3,
  parameter int DATA_W  = 32,
  parameter int LABEL_W = 4
);
  logic [NUM_SRC-1:0]         require;
  logic [NUM_SRC*LABEL_W-1:0] labelIn;
  logic [NUM_SRC*DATA_W-1:0]  dataIn;
  logic [NUM_SRC-1:0]         requireAC;
  logic                       BCEN;
  logic [LABEL_W-1:0]         BClabel;
  logic [DATA_W-1:0]          BCdata;
`ifdef CDB_ARBITER_STATS_EN
  logic [15:0]                bcCount;
  logic [15:0]                conflictCount;

  modport master (
    output require, labelIn, dataIn,
    input  requireAC, BCEN, BClabel, BCdata, bcCount, conflictCount
  );

  modport slave (
    input  require, labelIn, dataIn,
    output requireAC, BCEN, BClabel, BCdata, bcCount, conflictCount
  );
`else
  modport master (
    output require, labelIn, dataIn,
    input  requireAC, BCEN, BClabel, BCdata
  );

  modport slave (
    input  require, labelIn, dataIn,
    output requireAC, BCEN, BClabel, BCdata
  );
`endif
endinterface

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin common-data-bus arbiter with registered broadcast (optional CDB_ARBITER_STATS_EN counters)
module cdb_arbiter #(
  parameter int NUM_SRC = 3,
  parameter int DATA_W  = 32,
  parameter int LABEL_W = 4
) (
  input  logic            clk,
  input  logic            nRST,
  cdb_arbiter_if.slave    bus
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [PTR_W-1:0]   r_rr_ptr;
  logic               r_bcen;
  logic [LABEL_W-1:0] r_bclabel;
  logic [DATA_W-1:0]  r_bcdata;

  logic               w_hi_found;
  logic [PTR_W-1:0]   w_hi_idx;
  logic               w_lo_found;
  logic [PTR_W-1:0]   w_lo_idx;
  logic               w_grant_any;
  logic [PTR_W-1:0]   w_grant_idx;
  logic [NUM_SRC-1:0] w_grant_oh;
  logic [LABEL_W-1:0] w_grant_label;
  logic [DATA_W-1:0]  w_grant_data;
  logic               w_bcen_next;

  // Round-robin search: lowest requester at or above the pointer wins, else lowest overall (the wrap)
  always_comb begin
    w_hi_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_found = 1'b0;
    w_lo_idx   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (bus.require[i]) begin
        w_lo_found = 1'b1;
        w_lo_idx   = PTR_W'(i);
        if (i >= int'(r_rr_ptr)) begin
          w_hi_found = 1'b1;
          w_hi_idx   = PTR_W'(i);
        end
      end
    end
  end

  assign w_grant_any = w_hi_found | w_lo_found;
  assign w_grant_idx = w_hi_found ? w_hi_idx : w_lo_idx;

  // Grant is suppressed while reset is asserted so no source sees a phantom ack
  assign w_grant_oh    = (w_grant_any && nRST) ? (NUM_SRC'(1) << w_grant_idx) : '0;
  assign w_grant_label = bus.labelIn[w_grant_idx*LABEL_W +: LABEL_W];
  assign w_grant_data  = bus.dataIn[w_grant_idx*DATA_W +: DATA_W];

  // Label 0 means "no producer": the source is still released but nothing is broadcast
  assign w_bcen_next = w_grant_any && (w_grant_label != '0);

  // Pointer advance and broadcast register; label/data hold when nothing is broadcast
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_rr_ptr  <= '0;
      r_bcen    <= 1'b0;
      r_bclabel <= '0;
      r_bcdata  <= '0;
    end else begin
      r_bcen <= w_bcen_next;
      if (w_grant_any) begin
        r_rr_ptr <= (w_grant_idx == PTR_W'(NUM_SRC - 1)) ? '0 : w_grant_idx + PTR_W'(1);
      end
      if (w_bcen_next) begin
        r_bclabel <= w_grant_label;
        r_bcdata  <= w_grant_data;
      end
    end
  end

  assign bus.requireAC = w_grant_oh;
  assign bus.BCEN      = r_bcen;
  assign bus.BClabel   = r_bclabel;
  assign bus.BCdata    = r_bcdata;

`ifdef CDB_ARBITER_STATS_EN
  logic [15:0] r_bc_count;
  logic [15:0] r_conflict_count;
  logic        w_conflict;

  assign w_conflict = ($countones(bus.require) > 1);

  // Broadcast count tracks BCEN cycles (wraps); conflict count tracks multi-request cycles (saturates)
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_bc_count       <= '0;
      r_conflict_count <= '0;
    end else begin
      if (w_bcen_next) begin
        r_bc_count <= r_bc_count + 16'd1;
      end
      if (w_conflict && (r_conflict_count != 16'hFFFF)) begin
        r_conflict_count <= r_conflict_count + 16'd1;
      end
    end
  end

  assign bus.bcCount       = r_bc_count;
  assign bus.conflictCount = r_conflict_count;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - scoreboard bench for cdb_arbiter
module tb_cdb_arbiter;

  localparam int NS = 3;
  localparam int DW = 32;
  localparam int LW = 4;

  typedef struct {
    logic [LW-1:0] label;
    logic [DW-1:0] data;
  } bc_t;

  logic clk;
  logic nRST;

  cdb_arbiter_if #(.NUM_SRC(NS), .DATA_W(DW), .LABEL_W(LW)) bus ();

  cdb_arbiter #(.NUM_SRC(NS), .DATA_W(DW), .LABEL_W(LW)) dut (
    .clk  (clk),
    .nRST (nRST),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp  = 0;
  int n_fail = 0;

  bit            pend [NS];
  logic [LW-1:0] lab  [NS];
  logic [DW-1:0] dat  [NS];
  int            mptr;
  bc_t           q [$];
  logic [LW-1:0] last_lab;
  logic [DW-1:0] last_dat;
  int            bc_model;
  int            cf_model;
  bit            rand_en;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic set_src(int i, logic [LW-1:0] l, logic [DW-1:0] d);
    pend[i] = 1'b1;
    lab[i]  = l;
    dat[i]  = d;
  endtask

  task automatic drive();
    for (int i = 0; i < NS; i++) begin
      bus.require[i]            = pend[i];
      bus.labelIn[i*LW +: LW]   = lab[i];
      bus.dataIn[i*DW +: DW]    = dat[i];
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < NS; i++) pend[i] = 1'b0;
    q.delete();
    mptr     = 0;
    last_lab = '0;
    last_dat = '0;
    bc_model = 0;
    cf_model = 0;
  endtask

  // Reference: first pending source scanning upward from the model pointer, wrapping
  task automatic check_grant();
    int w;
    int nreq;
    logic [NS-1:0] expv;
    w    = -1;
    nreq = 0;
    for (int i = 0; i < NS; i++) if (pend[i]) nreq++;
    for (int k = 0; k < NS; k++) begin
      int idx;
      idx = (mptr + k) % NS;
      if (w < 0 && pend[idx]) w = idx;
    end
`ifdef CDB_ARBITER_STATS_EN
    chk("bcCount", 64'(bus.bcCount), 64'(16'(bc_model)));
    chk("conflictCount", 64'(bus.conflictCount), 64'(cf_model));
`endif
    expv = (w < 0) ? '0 : NS'(1 << w);
    chk("requireAC", 64'(bus.requireAC), 64'(expv));
    if (w >= 0) begin
      if (lab[w] != '0) begin
        q.push_back('{label: lab[w], data: dat[w]});
        bc_model++;
      end
      mptr    = (w + 1) % NS;
      pend[w] = 1'b0;
    end
    if (nreq > 1 && cf_model < 65535) cf_model++;
  endtask

  task automatic cycle();
    drive();
    @(negedge clk);
    #1;
    check_grant();
    @(posedge clk);
    #1;
    if (rand_en) begin
      for (int i = 0; i < NS; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          set_src(i, LW'($urandom_range(0, 15)), $urandom);
        end
      end
    end
  endtask

  // Monitor: each BCEN cycle consumes one expected broadcast; idle cycles must hold the last values
  always @(negedge clk) begin
    if (nRST) begin
      if (bus.BCEN) begin
        if (q.size() == 0) begin
          chk("bcen_spurious", 64'(bus.BCEN), 64'd0);
        end else begin
          bc_t e;
          e = q.pop_front();
          chk("BClabel", 64'(bus.BClabel), 64'(e.label));
          chk("BCdata", 64'(bus.BCdata), 64'(e.data));
          last_lab = e.label;
          last_dat = e.data;
        end
      end else begin
        if (q.size() != 0) begin
          bc_t e;
          e = q.pop_front();
          chk("bcen_missing", 64'(bus.BCEN), 64'd1);
        end
        chk("BClabel_hold", 64'(bus.BClabel), 64'(last_lab));
        chk("BCdata_hold", 64'(bus.BCdata), 64'(last_dat));
      end
    end
  end

  initial begin
    rand_en = 1'b0;
    for (int i = 0; i < NS; i++) begin
      lab[i] = '0;
      dat[i] = '0;
    end
    clear_model();
    nRST = 1'b0;
    for (int i = 0; i < NS; i++) pend[i] = 1'b1;
    drive();
    #1;
    chk("rst_requireAC", 64'(bus.requireAC), 64'd0);
    chk("rst_BCEN", 64'(bus.BCEN), 64'd0);
    chk("rst_BClabel", 64'(bus.BClabel), 64'd0);
    chk("rst_BCdata", 64'(bus.BCdata), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    clear_model();
    nRST = 1'b1;

    // Single request
    set_src(0, 4'h5, 32'h0000_00AA);
    repeat (3) cycle();

    // Full contention, then rotation from pointer 2
    set_src(0, 4'h1, 32'h10);
    set_src(1, 4'h2, 32'h20);
    set_src(2, 4'h3, 32'h30);
    repeat (5) cycle();
    set_src(1, 4'h4, 32'h40);
    cycle();
    set_src(0, 4'h6, 32'h60);
    set_src(1, 4'h7, 32'h70);
    repeat (3) cycle();

    // Label 0 releases the source without broadcasting
    set_src(1, 4'h0, 32'hDEAD);
    repeat (3) cycle();

    // Async reset while a broadcast is on the bus
    set_src(0, 4'h7, 32'h77);
    cycle();
    set_src(2, 4'h9, 32'h99);
    drive();
    #2;
    nRST = 1'b0;
    #1;
    chk("mid_rst_BCEN", 64'(bus.BCEN), 64'd0);
    chk("mid_rst_BClabel", 64'(bus.BClabel), 64'd0);
    chk("mid_rst_BCdata", 64'(bus.BCdata), 64'd0);
    chk("mid_rst_requireAC", 64'(bus.requireAC), 64'd0);
    clear_model();
    set_src(2, 4'h9, 32'h99);
    @(posedge clk);
    #1;
    nRST = 1'b1;
    repeat (3) cycle();

    // Randomized traffic
    rand_en = 1'b1;
    repeat (400) cycle();
    rand_en = 1'b0;
    repeat (6) cycle();
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
